fusion_mac_seq: RTL
===================

Name: fusion_mac_seq

Overview:
- Sequencer that runs one fusion_unit through a multi-beat multiply-accumulate job.
- Latches the precision/sign configuration and preloads a bias.
- Streams operand beats from an upstream buffer with a valid/ready handshake, carries the running partial sum through the unit's psum_in/psum_fwd path, and returns the final 32-bit sum through a valid/ready result port.
- Sits between the operand buffers and one fusion_unit instance inside a PE.

Parameters:
CNT_W, 16, width of the beat-count field and the internal beat counter.

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  job request; sampled only in IDLE
cfg_in_width  input  4  input bit width (2, 4 or 8), latched on start
cfg_weight_width  input  4  weight bit width (2, 4 or 8), latched on start
cfg_s_in  input  1  input signed flag, latched on start
cfg_s_weight  input  1  weight signed flag, latched on start
cfg_len  input  CNT_W  number of operand beats in the job, latched on start
cfg_bias  input  32  accumulator initial value, latched on start
busy  output  1  high in RUN and DONE
op_valid  input  1  operand beat present
op_ready  output  1  controller accepts a beat
op_in  input  8  packed input operand
op_weight  input  8  packed weight operand
fu_in  output  8  to fusion_unit.in
fu_weight  output  8  to fusion_unit.weight
fu_psum_in  output  32  to fusion_unit.psum_in
fu_in_width  output  4  to fusion_unit.in_width
fu_weight_width  output  4  to fusion_unit.weight_width
fu_s_in  output  1  to fusion_unit.s_in
fu_s_weight  output  1  to fusion_unit.s_weight
fu_psum_fwd  input  32  from fusion_unit.psum_fwd (combinational)
res_valid  output  1  result available
res_ready  input  1  result consumer ready
res_data  output  32  final accumulated sum
cfg_err  output  1  sticky: the last job had an illegal width

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, acc=0, beat count=0, busy=0, op_ready=0, res_valid=0, res_data=0, cfg_err=0, all cfg registers=0.
- The fusion_unit configuration ports are driven from the latched cfg registers and are stable for the whole job.
- IDLE:
  - On start=1, latch all cfg_* fields, set acc=cfg_bias and count=0, and clear cfg_err.
  - If either width is not in {2,4,8}: set cfg_err=1, acc=0, go to DONE.
  - Else if cfg_len==0: go to DONE with acc=cfg_bias.
  - Else go to RUN.
- RUN:
  - op_ready=1.
  - fu_in/fu_weight = op_in/op_weight when op_valid=1, else 0 (operand gating).
  - fu_psum_in = acc.
  - A beat is accepted when op_valid & op_ready. On acceptance: acc <= fu_psum_fwd, count <= count+1.
  - When the accepted beat is beat cfg_len (count==cfg_len-1), go to DONE next cycle.
  - No accepted beat: acc and count hold.
- DONE:
  - op_ready=0 and fu operands=0.
  - res_valid=1, res_data=acc, both held stable until res_ready=1.
  - On res_valid & res_ready, go to IDLE the next cycle with res_valid=0.
  - res_valid may assert in the cycle after start when the job is zero-length or erroneous.
- Latency: a job of L beats with op_valid held high has res_valid rising exactly L+1 cycles after the start cycle.
- Arithmetic: 32-bit two's-complement wrap (mod 2^32), no saturation.
- Boundaries:
  - start outside IDLE is ignored.
  - start in the same cycle as the DONE→IDLE result handshake is ignored; start is accepted only from the IDLE state.
  - cfg_len is never re-sampled mid-job.
  - cfg_err stays set until the next accepted start.
  - rst mid-RUN or mid-DONE aborts the job and returns all outputs to their reset values the next cycle; the pending result is dropped.
  - op_ready never depends combinationally on op_valid.

Test Plan:
- 8b unsigned: bias=10, len=3, beats (2,3),(4,5),(1,1) back-to-back → res_data=37, res_valid rises 4 cycles after start, op_ready low afterwards.
- 8b signed: s_in=s_weight=1, bias=0, len=2, beats (0xFF,0x02),(0x03,0x04) → res_data=0x0000000A (-2+12).
- Backpressure/stall: same job as the first scenario with op_valid low for 3 cycles between beats 1 and 2, and res_ready held low for 5 cycles → acc holds during the gap, fu_in=0 during the gap, res_data=37 held stable until the handshake.
- Corner configs:
  - len=0, bias=0x12345678 → res_data=0x12345678 one cycle after start, no op_ready.
  - cfg_in_width=3 → cfg_err=1, res_data=0; cfg_err clears on the next valid start.
- Wrap and abort:
  - bias=0xFFFFFFFF, one beat (1,1) → res_data=0.
  - rst asserted after beat 1 of a 3-beat job → busy=0, res_valid=0, acc=0; a new job then computes correctly.
- start pulses during RUN and during DONE → ignored; the in-flight result is unchanged.

Source files
------------

// File: rtl/fusion_mac_seq.sv
// Job sequencer for one fusion_unit: latches the precision config and bias,
// streams operand beats through the unit's psum path and returns the final sum.
module fusion_mac_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       cfg_in_width,
  input  logic [3:0]       cfg_weight_width,
  input  logic             cfg_s_in,
  input  logic             cfg_s_weight,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [31:0]      cfg_bias,
  output logic             busy,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_in,
  input  logic [7:0]       op_weight,
  output logic [7:0]       fu_in,
  output logic [7:0]       fu_weight,
  output logic [31:0]      fu_psum_in,
  output logic [3:0]       fu_in_width,
  output logic [3:0]       fu_weight_width,
  output logic             fu_s_in,
  output logic             fu_s_weight,
  input  logic [31:0]      fu_psum_fwd,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [31:0]      acc;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] len_q;
  logic [3:0]       in_w_q;
  logic [3:0]       wt_w_q;
  logic             s_in_q;
  logic             s_wt_q;
  logic             accept;
  logic             last_beat;
  logic             cfg_bad;

  function automatic logic width_ok(input logic [3:0] w);
    return (w == 4'd2) || (w == 4'd4) || (w == 4'd8);
  endfunction

  // op_ready is a register that mirrors state==RUN, so it never depends on op_valid
  assign accept    = op_ready & op_valid;
  assign last_beat = (count == (len_q - CNT_W'(1)));
  assign cfg_bad   = !width_ok(cfg_in_width) || !width_ok(cfg_weight_width);

  assign fu_psum_in      = acc;
  assign fu_in_width     = in_w_q;
  assign fu_weight_width = wt_w_q;
  assign fu_s_in         = s_in_q;
  assign fu_s_weight     = s_wt_q;

  always_comb begin
    fu_in     = '0;
    fu_weight = '0;
    if (accept) begin
      fu_in     = op_in;
      fu_weight = op_weight;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      len_q     <= '0;
      in_w_q    <= '0;
      wt_w_q    <= '0;
      s_in_q    <= 1'b0;
      s_wt_q    <= 1'b0;
      busy      <= 1'b0;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      cfg_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            in_w_q  <= cfg_in_width;
            wt_w_q  <= cfg_weight_width;
            s_in_q  <= cfg_s_in;
            s_wt_q  <= cfg_s_weight;
            len_q   <= cfg_len;
            count   <= '0;
            busy    <= 1'b1;
            cfg_err <= 1'b0;
            if (cfg_bad) begin
              cfg_err   <= 1'b1;
              acc       <= '0;
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= DONE;
            end else if (cfg_len == '0) begin
              acc       <= cfg_bias;
              res_data  <= cfg_bias;
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              acc      <= cfg_bias;
              op_ready <= 1'b1;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          if (accept) begin
            acc   <= fu_psum_fwd;
            count <= count + CNT_W'(1);
            if (last_beat) begin
              op_ready  <= 1'b0;
              res_valid <= 1'b1;
              res_data  <= fu_psum_fwd;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
